// File: rtl/bpred_pkg.sv
// bpred_pkg - shared types, counter constants and helpers for the fetch-stage branch predictor.
package bpred_pkg;

  typedef enum logic [1:0] {
    COND   = 2'd0,
    UNCOND = 2'd1,
    CALL   = 2'd2,
    RET    = 2'd3
  } btb_kind_e;

  localparam logic [1:0] SC_WNT = 2'b01;
  localparam logic [1:0] SC_MAX = 2'b11;

  // Two-bit saturating counter step: up on taken, down on not-taken, clamped at both ends.
  function automatic logic [1:0] sc_update(input logic [1:0] sc, input logic taken);
    logic [1:0] nxt;
    nxt = sc;
    if (taken) begin
      if (sc != SC_MAX) nxt = sc + 2'd1;
    end else begin
      if (sc != 2'b00) nxt = sc - 2'd1;
    end
    return nxt;
  endfunction

  // Meta carries the PHT index plus the 2-bit counter that was read with it.
  function automatic int meta_width(input int idx_w);
    return idx_w + 2;
  endfunction

endpackage

// File: rtl/bpred_ras.sv
// bpred_ras - circular return-address stack with push, pop and whole-state load from another copy.
// ptr points at the next free slot; the top of stack lives at ptr-1.
module bpred_ras
  import bpred_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [31:0]            push_addr,
  input  logic                   load,
  input  logic [DEPTH-1:0][31:0] load_entries,
  input  logic [PTR_W-1:0]       load_ptr,
  input  logic [CNT_W-1:0]       load_count,
  output logic [DEPTH-1:0][31:0] entries,
  output logic [PTR_W-1:0]       ptr,
  output logic [CNT_W-1:0]       count,
  output logic [31:0]            top,
  output logic                   empty
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0][31:0] entries_q, entries_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Next stack state: load wins, then pop+push replaces the top, then plain push (wrapping over the oldest), then pop.
  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (load) begin
      entries_d = load_entries;
      ptr_d     = load_ptr;
      count_d   = load_count;
    end else if (push && pop && (count_q != '0)) begin
      entries_d[ptr_q - PTR_W'(1)] = push_addr;
    end else if (push) begin
      entries_d[ptr_q] = push_addr;
      ptr_d            = ptr_q + PTR_W'(1);
      if (count_q != FULL) count_d = count_q + CNT_W'(1);
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  // Stack state register; reset empties the stack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
    end
  end

  assign entries = entries_q;
  assign ptr     = ptr_q;
  assign count   = count_q;
  assign top     = entries_q[ptr_q - PTR_W'(1)];
  assign empty   = (count_q == '0);

endmodule

// File: rtl/branch_predictor_ras.sv
// branch_predictor_ras - gshare direction table plus direct-mapped tagged BTB for the fetch stage.
// Define BPRED_RAS_EN to build the speculative and committed return-address stacks.
module branch_predictor_ras #(
  parameter int PHT_IDX_W = 6,
  parameter int GHR_W     = 6,
  parameter int BTB_IDX_W = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_addr,
  input  logic                 id_stall,
  input  logic                 wb_flush,
  input  logic [31:0]          ex_addr,
  input  logic [31:0]          ex_target,
  input  logic                 ex_target_valid,
  input  logic                 ex_br_inst,
  input  logic                 ex_br_taken,
  input  logic                 ex_is_uncond,
  input  logic                 ex_is_call,
  input  logic                 ex_is_ret,
  input  logic [PHT_IDX_W+1:0] ex_meta,
  output logic [31:0]          id_target,
  output logic                 id_target_taken,
  output logic [PHT_IDX_W+1:0] id_meta
);
  import bpred_pkg::*;

  localparam int META_W      = meta_width(PHT_IDX_W);
  localparam int PHT_ENTRIES = 1 << PHT_IDX_W;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W       = 30 - BTB_IDX_W;

  logic [1:0]       pht_q [PHT_ENTRIES];
  logic [1:0]       pht_d [PHT_ENTRIES];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             btb_valid_q [BTB_ENTRIES];
  logic             btb_valid_d [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_d [BTB_ENTRIES];
  logic [31:0]      btb_target_q [BTB_ENTRIES];
  logic [31:0]      btb_target_d [BTB_ENTRIES];
  btb_kind_e        btb_kind_q [BTB_ENTRIES];
  btb_kind_e        btb_kind_d [BTB_ENTRIES];

  logic [PHT_IDX_W-1:0] ghr_ext, if_pht_idx, ex_pht_idx;
  logic [1:0]           if_sc;
  logic [BTB_IDX_W-1:0] if_btb_idx, ex_btb_idx;
  logic                 if_hit;
  btb_kind_e            if_kind, ex_kind;
  logic [GHR_W:0]       ghr_shift;
  logic [31:0]          sp_top;
  logic                 sp_empty;

`ifdef BPRED_RAS_EN
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  logic [RAS_DEPTH-1:0][31:0] cm_entries, sp_entries_unused;
  logic [RAS_PTR_W-1:0]       cm_ptr, sp_ptr_unused;
  logic [RAS_CNT_W-1:0]       cm_count, sp_count_unused;
  logic [31:0]                cm_top_unused;
  logic                       cm_empty_unused;
  logic                       sp_push, sp_pop, cm_push, cm_pop;

  assign sp_push = if_hit && (if_kind == CALL) && !id_stall && !wb_flush;
  assign sp_pop  = if_hit && (if_kind == RET)  && !id_stall && !wb_flush;
  assign cm_push = ex_is_call && !wb_flush;
  assign cm_pop  = ex_is_ret  && !wb_flush;

  bpred_ras #(.DEPTH(RAS_DEPTH)) u_ras_spec (
    .clk          (clk),
    .rst          (rst),
    .push         (sp_push),
    .pop          (sp_pop),
    .push_addr    (if_addr + 32'd4),
    .load         (wb_flush),
    .load_entries (cm_entries),
    .load_ptr     (cm_ptr),
    .load_count   (cm_count),
    .entries      (sp_entries_unused),
    .ptr          (sp_ptr_unused),
    .count        (sp_count_unused),
    .top          (sp_top),
    .empty        (sp_empty)
  );

  bpred_ras #(.DEPTH(RAS_DEPTH)) u_ras_commit (
    .clk          (clk),
    .rst          (rst),
    .push         (cm_push),
    .pop          (cm_pop),
    .push_addr    (ex_addr + 32'd4),
    .load         (1'b0),
    .load_entries ('0),
    .load_ptr     ('0),
    .load_count   ('0),
    .entries      (cm_entries),
    .ptr          (cm_ptr),
    .count        (cm_count),
    .top          (cm_top_unused),
    .empty        (cm_empty_unused)
  );
`else
  logic unused_inputs;

  assign sp_top        = '0;
  assign sp_empty      = 1'b1;
  assign unused_inputs = ^{id_stall, if_addr[1:0], ex_addr[1:0]};
`endif

  // Fetch lookup: gshare counter read, BTB tag match, and return target taken from the RAS when it has one.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_W-1:0]     = ghr_q;
    if_pht_idx             = if_addr[PHT_IDX_W+1:2] ^ ghr_ext;
    if_sc                  = pht_q[if_pht_idx];
    id_meta                = {if_pht_idx, if_sc};
    if_btb_idx             = if_addr[BTB_IDX_W+1:2];
    if_kind                = btb_kind_q[if_btb_idx];
    if_hit                 = btb_valid_q[if_btb_idx] &&
                             (btb_tag_q[if_btb_idx] == if_addr[31:BTB_IDX_W+2]);
    id_target_taken        = if_hit && ((if_kind != COND) || if_sc[1]);
    id_target              = btb_target_q[if_btb_idx];
    if (if_hit && (if_kind == RET) && !sp_empty) id_target = sp_top;
  end

  // Training from EX, suppressed while WB flushes: counter update, history shift and BTB fill.
  always_comb begin
    pht_d        = pht_q;
    ghr_d        = ghr_q;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_kind_d   = btb_kind_q;
    ex_pht_idx   = ex_meta[META_W-1:2];
    ex_btb_idx   = ex_addr[BTB_IDX_W+1:2];
    ghr_shift    = {ghr_q, ex_br_taken};
    if (ex_is_ret)         ex_kind = RET;
    else if (ex_is_call)   ex_kind = CALL;
    else if (ex_is_uncond) ex_kind = UNCOND;
    else                   ex_kind = COND;
    if (!wb_flush && ex_br_inst) begin
      pht_d[ex_pht_idx] = sc_update(ex_meta[1:0], ex_br_taken);
      ghr_d             = ghr_shift[GHR_W-1:0];
    end
    if (!wb_flush && ex_target_valid) begin
      btb_valid_d[ex_btb_idx]  = 1'b1;
      btb_tag_d[ex_btb_idx]    = ex_addr[31:BTB_IDX_W+2];
      btb_target_d[ex_btb_idx] = ex_target;
      btb_kind_d[ex_btb_idx]   = ex_kind;
    end
  end

  // Predictor state registers; reset clears the BTB, weakly-not-takens the PHT and zeroes history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= SC_WNT;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_kind_q[i]   <= COND;
      end
      ghr_q <= '0;
    end else begin
      pht_q        <= pht_d;
      ghr_q        <= ghr_d;
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      btb_kind_q   <= btb_kind_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_ras.sv
// tb_branch_predictor_ras - directed self-checking bench for branch_predictor_ras.
// RAS scenarios run only when BPRED_RAS_EN is defined.
module tb_branch_predictor_ras;

  localparam int PHT_IDX_W = 6;
  localparam int GHR_W     = 6;
  localparam int BTB_IDX_W = 4;
  localparam int RAS_DEPTH = 4;
  localparam int META_W    = PHT_IDX_W + 2;
  localparam logic [31:0] IDLE_PC = 32'h0000_00FC;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       if_addr;
  logic              id_stall;
  logic              wb_flush;
  logic [31:0]       ex_addr;
  logic [31:0]       ex_target;
  logic              ex_target_valid;
  logic              ex_br_inst;
  logic              ex_br_taken;
  logic              ex_is_uncond;
  logic              ex_is_call;
  logic              ex_is_ret;
  logic [META_W-1:0] ex_meta;
  logic [31:0]       id_target;
  logic              id_target_taken;
  logic [META_W-1:0] id_meta;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  branch_predictor_ras #(
    .PHT_IDX_W (PHT_IDX_W),
    .GHR_W     (GHR_W),
    .BTB_IDX_W (BTB_IDX_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_addr         (if_addr),
    .id_stall        (id_stall),
    .wb_flush        (wb_flush),
    .ex_addr         (ex_addr),
    .ex_target       (ex_target),
    .ex_target_valid (ex_target_valid),
    .ex_br_inst      (ex_br_inst),
    .ex_br_taken     (ex_br_taken),
    .ex_is_uncond    (ex_is_uncond),
    .ex_is_call      (ex_is_call),
    .ex_is_ret       (ex_is_ret),
    .ex_meta         (ex_meta),
    .id_target       (id_target),
    .id_target_taken (id_target_taken),
    .id_meta         (id_meta)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  task automatic checkLookup(input string tag, input logic [31:0] addr, input logic expTaken,
                             input logic [31:0] expTarget);
    if_addr = addr;
    @(negedge clk);
    checkOutput({tag, "_taken"}, {31'd0, id_target_taken}, {31'd0, expTaken});
    checkOutput({tag, "_target"}, id_target, expTarget);
  endtask

  task automatic checkMeta(input string tag, input logic [META_W-1:0] expMeta);
    checkOutput({tag, "_meta"}, {24'd0, id_meta}, {24'd0, expMeta});
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] target, input logic tv,
                               input logic br, input logic taken, input logic uncond,
                               input logic call, input logic ret, input logic [META_W-1:0] meta,
                               input logic flush);
    if_addr         = IDLE_PC;
    ex_addr         = addr;
    ex_target       = target;
    ex_target_valid = tv;
    ex_br_inst      = br;
    ex_br_taken     = taken;
    ex_is_uncond    = uncond;
    ex_is_call      = call;
    ex_is_ret       = ret;
    ex_meta         = meta;
    wb_flush        = flush;
    tick();
    ex_target_valid = 1'b0;
    ex_br_inst      = 1'b0;
    ex_br_taken     = 1'b0;
    ex_is_uncond    = 1'b0;
    ex_is_call      = 1'b0;
    ex_is_ret       = 1'b0;
    ex_meta         = '0;
    wb_flush        = 1'b0;
  endtask

  // Shift zeros through the history; the dummy counter write hits idx 63 with 00 -> 00.
  task automatic clearHistory();
    for (int i = 0; i < GHR_W; i++)
      applyStimulus(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFC, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] addr);
    if_addr = addr;
    tick();
    if_addr = IDLE_PC;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; if_addr = 32'h100; id_stall = 1'b0; wb_flush = 1'b0;
    ex_addr = '0; ex_target = '0; ex_target_valid = 1'b0; ex_br_inst = 1'b0;
    ex_br_taken = 1'b0; ex_is_uncond = 1'b0; ex_is_call = 1'b0; ex_is_ret = 1'b0; ex_meta = '0;
    #2 rst = 1'b0;
    #1;
    $display("[TB] outputs while in reset");
    checkOutput("inrst_taken", {31'd0, id_target_taken}, 32'd0);
    checkOutput("inrst_target", id_target, 32'd0);
    checkMeta("inrst", 8'h01);
    tick(); tick();
    rst = 1'b1;
    tick();

    $display("[TB] lookup after reset");
    checkLookup("rst_lookup", 32'h100, 1'b0, 32'h0);
    checkMeta("rst_lookup", 8'h01);

    $display("[TB] conditional branch training at 0x200");
    applyStimulus(32'h200, 32'h180, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
    applyStimulus(32'h200, 32'h180, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);
    clearHistory();
    checkLookup("cond_t2", 32'h200, 1'b1, 32'h180);
    checkMeta("cond_t2", 8'h03);
    applyStimulus(32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0);
    checkLookup("cond_nt1", 32'h200, 1'b1, 32'h180);
    checkMeta("cond_nt1", 8'h02);
    applyStimulus(32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);
    checkLookup("cond_nt2", 32'h200, 1'b0, 32'h180);
    checkMeta("cond_nt2", 8'h01);
    applyStimulus(32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
    applyStimulus(32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkLookup("cond_satlo", 32'h200, 1'b0, 32'h180);
    checkMeta("cond_satlo", 8'h00);

    $display("[TB] counter saturates high, history feeds the index");
    applyStimulus(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h17, 1'b0);
    checkLookup("sathi", 32'h010, 1'b0, 32'h0);
    checkMeta("sathi", 8'h17);
    clearHistory();

    $display("[TB] jal at 0x300, first under wb_flush");
    applyStimulus(32'h300, 32'h400, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkLookup("jal_flushed", 32'h300, 1'b0, 32'h180);
    checkMeta("jal_flushed", 8'h00);
    applyStimulus(32'h300, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkLookup("jal", 32'h300, 1'b1, 32'h400);

    $display("[TB] BTB aliasing 0x040 / 0x440");
    applyStimulus(32'h040, 32'h800, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h440, 32'h900, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkLookup("alias_old", 32'h040, 1'b0, 32'h900);
    checkLookup("alias_new", 32'h440, 1'b1, 32'h900);

    $display("[TB] call at 0x500 and return at 0x604");
    applyStimulus(32'h500, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h604, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    checkLookup("call", 32'h500, 1'b1, 32'h1000);
    checkLookup("ret_empty", 32'h604, 1'b1, 32'h2000);

`ifdef BPRED_RAS_EN
    $display("[TB] speculative push then pop");
    fetch(32'h500);
    checkLookup("ras_ret", 32'h604, 1'b1, 32'h504);
    fetch(32'h604);
    checkLookup("ras_popped", 32'h604, 1'b1, 32'h2000);

    $display("[TB] five nested calls into a depth-4 stack");
    for (int k = 1; k < 5; k++) begin
      applyStimulus(32'h500 + 32'(8 * k), 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(32'h604, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    end
    for (int k = 0; k < 5; k++) fetch(32'h500 + 32'(8 * k));
    for (int k = 0; k < 4; k++) begin
      checkLookup($sformatf("ras_nest%0d", k), 32'h604, 1'b1, 32'h524 - 32'(8 * k));
      fetch(32'h604);
    end
    checkLookup("ras_nest_fallback", 32'h604, 1'b1, 32'h2000);

    $display("[TB] id_stall holds the speculative stack");
    id_stall = 1'b1;
    fetch(32'h500);
    id_stall = 1'b0;
    checkLookup("ras_stall", 32'h604, 1'b1, 32'h2000);

    $display("[TB] wb_flush restores an empty committed stack");
    fetch(32'h500);
    if_addr  = 32'h500;
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    if_addr  = IDLE_PC;
    checkLookup("ras_flush", 32'h604, 1'b1, 32'h2000);

    $display("[TB] committed call+ret replaces top, then flush copies it");
    applyStimulus(32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h700, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkLookup("ras_commit_top", 32'h604, 1'b1, 32'h704);
    fetch(32'h604);
    checkLookup("ras_commit_cnt", 32'h604, 1'b1, 32'h2000);
`else
    $display("[TB] RET entries use the BTB target without a stack");
    fetch(32'h500);
    checkLookup("noras_ret", 32'h604, 1'b1, 32'h2000);
`endif

    $display("[TB] reset asserted mid-operation");
    if_addr = 32'h300;
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_taken", {31'd0, id_target_taken}, 32'd0);
    checkOutput("midrst_target", id_target, 32'd0);
    checkMeta("midrst", 8'h01);
    tick();
    rst = 1'b1;
    tick();
    checkLookup("postrst", 32'h300, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
